alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  ID->EX issue register for ALU-class MIPS instructions. Decodes the instruction word.
//  Registers ALUControl, alu_src1, alu_src2, destination and exception qualifiers.
//  Its outputs drive the EX-stage ALU directly; it is the producer end of the ALU operand/control interface.
//  Single-entry pipeline register with valid/ready handshake, stall and flush.
// PARAMETERS
//  CNT_W  32  width of issued-instruction and reserved-instruction counters
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  resetn       in   1      asynchronous reset, active low
//  id_valid     in   1      ID holds an instruction
//  id_ready     out  1      stage accepts this cycle
//  id_inst      in   32     instruction word
//  id_rs_val    in   32     forwarded GPR[rs]
//  id_rt_val    in   32     forwarded GPR[rt]
//  id_pc        in   32     PC of instruction
//  flush        in   1      kill held and incoming instruction
//  ex_valid     out  1      EX operands valid
//  ex_ready     in   1      EX consumes this cycle
//  ALUControl   out  5      ALU op encoding (below)
//  alu_src1     out  32     ALU operand 1
//  alu_src2     out  32     ALU operand 2
//  ex_dest      out  5      destination GPR
//  ex_we        out  1      GPR write enable
//  ex_ov_en     out  1      ALU overflow (ExcepOv) is a trap for this op
//  ex_ri        out  1      reserved-instruction exception
//  ex_pc        out  32     PC of held instruction
//  issue_cnt    out  CNT_W  count of transfers to EX
//  ri_cnt       out  CNT_W  count of transfers with ex_ri=1
// BEHAVIOUR
//  Reset: all outputs are 0, including ex_valid and both counters.
//  Handshake:
//   - id_ready = !ex_valid | ex_ready.
//   - Load when id_valid & id_ready & !flush; then ex_valid=1 next cycle.
//   - Load latency is 1 cycle.
//   - If ex_valid & ex_ready & no load, ex_valid=0 next cycle.
//   - ex_valid=0 with id_valid=0 leaves payload regs held.
//   - While ex_valid & !ex_ready: all payload outputs are stable.
//  flush wins over everything: ex_valid=0 next cycle, incoming is dropped, counters are unchanged.
//  Counters:
//   - issue_cnt++ on ex_valid & ex_ready & !flush.
//   - ri_cnt++ on the same transfer when ex_ri=1.
//   - Both wrap modulo 2^CNT_W.
//  ALUControl encoding:
//   0 addu/addiu        1 lui            2 subu          3 slt/slti      4 sltu/sltiu
//   5 and/andi          6 or/ori         7 xor/xori      8 nor
//   9 sll/sllv          10 srl/srlv      11 sra/srav     12 add/addi     13 sub
//  Decode fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], funct=[5:0], imm=[15:0].
//  R-type ops (op=0):
//   - funct 00/02/03: sll/srl/sra. src1={27'b0,sa}, src2=rt_val.
//   - funct 04/06/07: sllv/srlv/srav. src1=rs_val, src2=rt_val.
//   - funct 20-27, 2A, 2B: add, addu, sub, subu, and, or, xor, nor, slt, sltu. src1=rs_val, src2=rt_val.
//   - dest=rd.
//  I-type ops:
//   - op 08-0F: addi, addiu, slti, sltiu, andi, ori, xori, lui.
//   - src1=rs_val; dest=rt.
//   - src2 is zero-extended imm for andi/ori/xori; sign-extended imm for all others.
//   - lui: src2={16'b0,imm}, since the ALU shifts by 16.
//  ex_we=1 for decoded ops with dest!=0; dest=0 gives ex_we=0, no exception.
//  ex_ov_en=1 only for ALUControl 12/13 (add, addi, sub).
//  Any other encoding:
//   - ex_ri=1; ALUControl=0; src1=src2=0; dest=0; we=0; ov_en=0.
//   - This includes an R-type with an unlisted funct.
// TESTING
//  1 reset mid-stream (ex_valid=1) -> all outputs 0 immediately, ex_valid stays 0 until the next load.
//  2 addi $3,$1,-1 (0x2023FFFF), rs_val=5
//    -> next cycle: ALUControl=12, src1=5, src2=0xFFFFFFFF, dest=3, we=1, ov_en=1.
//  3 ori $2,$0,0x8000 -> src2=0x00008000. sra $4,$5,31 with rt_val=0x80000000
//    -> ALUControl=11, src1=31, src2=0x80000000.
//  4 ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0, outputs held.
//    ex_ready=1 -> transfer, next instruction loads the same edge, issue_cnt+1.
//  5 flush while ex_valid=1 & id_valid=1 -> ex_valid=0 next cycle, counters unchanged.
//  6 inst 0xFC000000 -> ex_ri=1, we=0, ALUControl=0; on transfer ri_cnt=1.
//    Counter at 2^CNT_W-1 wraps to 0.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// ALU operand/control bundle between the issue register and the EX-stage ALU.
// Latency: none, wires only.
// Backpressure: ex_ready from the consumer stalls the producer while ex_valid is high.
interface alu_issue_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ALUControl;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [4:0]  ex_dest;
    logic        ex_we;
    logic        ex_ov_en;
    logic        ex_ri;
    logic [31:0] ex_pc;

    modport master (
        output ex_valid, ALUControl, alu_src1, alu_src2, ex_dest,
               ex_we, ex_ov_en, ex_ri, ex_pc,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ALUControl, alu_src1, alu_src2, ex_dest,
               ex_we, ex_ov_en, ex_ri, ex_pc,
        output ex_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue register for ALU-class MIPS instructions: decode, operand select, RI detection.
// Latency: 1 cycle from accepted id_valid to ex_valid.
// Backpressure: id_ready = !ex_valid | ex_ready; payload held stable while ex_valid & !ex_ready.
module alu_issue_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_inst,
    input  logic [31:0]      id_rs_val,
    input  logic [31:0]      id_rt_val,
    input  logic [31:0]      id_pc,
    input  logic             flush,
    alu_issue_stage_if.master ex,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] ri_cnt
);

    // Instruction fields
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        unused_rs_field;

    assign op              = id_inst[31:26];
    assign rt              = id_inst[20:16];
    assign rd              = id_inst[15:11];
    assign sa              = id_inst[10:6];
    assign funct           = id_inst[5:0];
    assign imm             = id_inst[15:0];
    // rs arrives already resolved as id_rs_val, so the field itself is not needed
    assign unused_rs_field = ^id_inst[25:21];

    // Decoded payload
    logic [4:0]  d_ctrl;
    logic [31:0] d_src1;
    logic [31:0] d_src2;
    logic [4:0]  d_dest;
    logic        d_ok;
    logic        d_we;
    logic        d_ov_en;

    // Held payload
    logic        v_q;
    logic [4:0]  ctrl_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [4:0]  dest_q;
    logic        we_q;
    logic        ov_en_q;
    logic        ri_q;
    logic [31:0] pc_q;

    logic        load;
    logic        xfer;

    assign id_ready = !v_q || ex.ex_ready;
    assign load     = id_valid && id_ready && !flush;
    assign xfer     = v_q && ex.ex_ready && !flush;

    // Decode instruction into ALU op, operands and destination; unknown encodings stay all-zero
    always_comb begin
        d_ctrl = 5'd0;
        d_src1 = 32'd0;
        d_src2 = 32'd0;
        d_dest = 5'd0;
        d_ok   = 1'b0;
        if (op == 6'h00) begin
            case (funct)
                6'h00: begin d_ok = 1'b1; d_ctrl = 5'd9;  d_src1 = {27'd0, sa}; d_src2 = id_rt_val; end
                6'h02: begin d_ok = 1'b1; d_ctrl = 5'd10; d_src1 = {27'd0, sa}; d_src2 = id_rt_val; end
                6'h03: begin d_ok = 1'b1; d_ctrl = 5'd11; d_src1 = {27'd0, sa}; d_src2 = id_rt_val; end
                6'h04: begin d_ok = 1'b1; d_ctrl = 5'd9;  d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h06: begin d_ok = 1'b1; d_ctrl = 5'd10; d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h07: begin d_ok = 1'b1; d_ctrl = 5'd11; d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h20: begin d_ok = 1'b1; d_ctrl = 5'd12; d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h21: begin d_ok = 1'b1; d_ctrl = 5'd0;  d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h22: begin d_ok = 1'b1; d_ctrl = 5'd13; d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h23: begin d_ok = 1'b1; d_ctrl = 5'd2;  d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h24: begin d_ok = 1'b1; d_ctrl = 5'd5;  d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h25: begin d_ok = 1'b1; d_ctrl = 5'd6;  d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h26: begin d_ok = 1'b1; d_ctrl = 5'd7;  d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h27: begin d_ok = 1'b1; d_ctrl = 5'd8;  d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h2A: begin d_ok = 1'b1; d_ctrl = 5'd3;  d_src1 = id_rs_val; d_src2 = id_rt_val; end
                6'h2B: begin d_ok = 1'b1; d_ctrl = 5'd4;  d_src1 = id_rs_val; d_src2 = id_rt_val; end
                default: ;
            endcase
            if (d_ok) d_dest = rd;
        end else begin
            case (op)
                6'h08: begin d_ok = 1'b1; d_ctrl = 5'd12; d_src2 = {{16{imm[15]}}, imm}; end
                6'h09: begin d_ok = 1'b1; d_ctrl = 5'd0;  d_src2 = {{16{imm[15]}}, imm}; end
                6'h0A: begin d_ok = 1'b1; d_ctrl = 5'd3;  d_src2 = {{16{imm[15]}}, imm}; end
                6'h0B: begin d_ok = 1'b1; d_ctrl = 5'd4;  d_src2 = {{16{imm[15]}}, imm}; end
                6'h0C: begin d_ok = 1'b1; d_ctrl = 5'd5;  d_src2 = {16'd0, imm}; end
                6'h0D: begin d_ok = 1'b1; d_ctrl = 5'd6;  d_src2 = {16'd0, imm}; end
                6'h0E: begin d_ok = 1'b1; d_ctrl = 5'd7;  d_src2 = {16'd0, imm}; end
                // The ALU performs the <<16 itself, so lui only passes the raw immediate
                6'h0F: begin d_ok = 1'b1; d_ctrl = 5'd1;  d_src2 = {16'd0, imm}; end
                default: ;
            endcase
            if (d_ok) begin
                d_src1 = id_rs_val;
                d_dest = rt;
            end
        end
    end

    assign d_we    = d_ok && (d_dest != 5'd0);
    assign d_ov_en = d_ok && ((d_ctrl == 5'd12) || (d_ctrl == 5'd13));

    // Pipeline register: flush kills, load captures, drain clears valid; payload otherwise held
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q     <= 1'b0;
            ctrl_q  <= 5'd0;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            dest_q  <= 5'd0;
            we_q    <= 1'b0;
            ov_en_q <= 1'b0;
            ri_q    <= 1'b0;
            pc_q    <= 32'd0;
        end else if (flush) begin
            v_q <= 1'b0;
        end else if (load) begin
            v_q     <= 1'b1;
            ctrl_q  <= d_ctrl;
            src1_q  <= d_src1;
            src2_q  <= d_src2;
            dest_q  <= d_dest;
            we_q    <= d_we;
            ov_en_q <= d_ov_en;
            ri_q    <= !d_ok;
            pc_q    <= id_pc;
        end else if (v_q && ex.ex_ready) begin
            v_q <= 1'b0;
        end
    end

    // Count transfers to EX and the subset that carry a reserved-instruction exception
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issue_cnt <= '0;
            ri_cnt    <= '0;
        end else if (xfer) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (ri_q) ri_cnt <= ri_cnt + CNT_W'(1);
        end
    end

    assign ex.ex_valid   = v_q;
    assign ex.ALUControl = ctrl_q;
    assign ex.alu_src1   = src1_q;
    assign ex.alu_src2   = src2_q;
    assign ex.ex_dest    = dest_q;
    assign ex.ex_we      = we_q;
    assign ex.ex_ov_en   = ov_en_q;
    assign ex.ex_ri      = ri_q;
    assign ex.ex_pc      = pc_q;

endmodule
